// File: rtl/ufm_csr_seq.sv
// Erase-and-reprogram sequencer for one UFM sector through the on-chip flash CSR port:
// unprotect, erase with status polling, hand off to the data writer, then re-protect.
module ufm_csr_seq #(
  parameter logic [23:0] POLL_LIMIT = 24'd12_000_000,
  parameter logic [31:0] CTRL_IDLE  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  sector,
  output logic        csr_addr,
  output logic        csr_read,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  input  logic [31:0] csr_readdata,
  output logic        write_go,
  input  logic        write_done,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [3:0] {
    IDLE, UNPROT, ERASE, E_RD, E_CHK, WR, PROT, DONE, ERR_PROT
  } state_t;

  state_t      state, state_n;
  logic [23:0] poll_cnt, poll_cnt_n, cnt_inc;
  logic [2:0]  sector_q, sector_n;
  logic        err_q, err_n;
  logic [1:0]  err_code_q, err_code_n;
  logic [31:0] unprot_word, erase_word;
  logic        unused_rd_bits;

  // Only the busy field and the erase-success bit of the status word matter here.
  assign unused_rd_bits = ^{csr_readdata[31:5], csr_readdata[3:2]};

  assign cnt_inc     = (poll_cnt == 24'hFF_FFFF) ? poll_cnt : poll_cnt + 24'd1;
  assign unprot_word = CTRL_IDLE & ~(32'd1 << (5'd22 + {2'b00, sector_q}));
  assign erase_word  = {unprot_word[31:23], sector_q, unprot_word[19:0]};

  assign err      = err_q;
  assign err_code = err_code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      poll_cnt   <= '0;
      sector_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state      <= state_n;
      poll_cnt   <= poll_cnt_n;
      sector_q   <= sector_n;
      err_q      <= err_n;
      err_code_q <= err_code_n;
    end
  end

  always_comb begin
    state_n       = state;
    poll_cnt_n    = poll_cnt;
    sector_n      = sector_q;
    err_n         = err_q;
    err_code_n    = err_code_q;
    csr_addr      = 1'b0;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_writedata = CTRL_IDLE;
    write_go      = 1'b0;
    done          = 1'b0;
    busy          = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (sector >= 3'd1 && sector <= 3'd5) begin
            sector_n   = sector;
            err_n      = 1'b0;
            err_code_n = 2'b00;
            state_n    = UNPROT;
          end else begin
            err_n      = 1'b1;
            err_code_n = 2'b01;
          end
        end
      end
      UNPROT: begin
        csr_write     = 1'b1;
        csr_addr      = 1'b1;
        csr_writedata = unprot_word;
        state_n       = ERASE;
      end
      ERASE: begin
        csr_write     = 1'b1;
        csr_addr      = 1'b1;
        csr_writedata = erase_word;
        poll_cnt_n    = '0;
        state_n       = E_RD;
      end
      E_RD: begin
        csr_read   = 1'b1;
        poll_cnt_n = cnt_inc;
        state_n    = E_CHK;
      end
      // A still-busy status only times out once the read budget is spent.
      E_CHK: begin
        if (csr_readdata[1:0] != 2'b00) begin
          if (poll_cnt >= POLL_LIMIT) begin
            err_n      = 1'b1;
            err_code_n = 2'b11;
            state_n    = ERR_PROT;
          end else begin
            state_n = E_RD;
          end
        end else if (csr_readdata[4]) begin
          poll_cnt_n = '0;
          state_n    = WR;
        end else begin
          err_n      = 1'b1;
          err_code_n = 2'b10;
          state_n    = ERR_PROT;
        end
      end
      WR: begin
        write_go   = 1'b1;
        poll_cnt_n = cnt_inc;
        if (write_done) begin
          state_n = PROT;
        end else if (cnt_inc >= POLL_LIMIT) begin
          err_n      = 1'b1;
          err_code_n = 2'b11;
          state_n    = ERR_PROT;
        end
      end
      PROT: begin
        csr_write = 1'b1;
        csr_addr  = 1'b1;
        state_n   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        busy    = 1'b0;
        state_n = IDLE;
      end
      ERR_PROT: begin
        csr_write = 1'b1;
        csr_addr  = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/ufm_csr_seq.md
UFM_CSR_SEQ -- requirements
Module: ufm_csr_seq

Interface
REQ-001 Parameter POLL_LIMIT, default 24'd12_000_000, max status polls per erase or write phase before timeout.
REQ-002 Parameter CTRL_IDLE, default 32'hFFFF_FFFF, protected/no-erase control word.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to erase and reprogram the UFM sector.
REQ-006 sector  input  3  target UFM sector (valid 1..5), sampled on accepted start.
REQ-007 csr_addr  output  1  UFM CSR address: 0 status, 1 control.
REQ-008 csr_read  output  1  CSR read strobe, one cycle.
REQ-009 csr_write  output  1  CSR write strobe, one cycle.
REQ-010 csr_writedata  output  32  CSR control word.
REQ-011 csr_readdata  input  32  CSR status, valid the cycle after csr_read.
REQ-012 write_go  output  1  level enable to the UFM data-write sequencer.
REQ-013 write_done  input  1  data-write sequencer finished all words.
REQ-014 busy  output  1  high from accepted start until DONE/ERR exit.
REQ-015 done  output  1  one-cycle pulse on successful completion.
REQ-016 err  output  1  sticky error flag, cleared on next accepted start.
REQ-017 err_code  output  2  01 bad sector, 10 erase fail, 11 timeout, 00 none.

Function
REQ-018 States: IDLE, UNPROT, ERASE, E_RD, E_CHK, WR, PROT, DONE, ERR_PROT.
REQ-019 IDLE: start=1 with sector 1..5 latches sector, clears err/err_code, -> UNPROT; start with sector 0/6/7 sets err=1, err_code=01, stays IDLE; start ignored in all other states.
REQ-020 UNPROT: csr_write=1, csr_addr=1, csr_writedata=CTRL_IDLE with bit (22+sector) cleared, one cycle -> ERASE.
REQ-021 ERASE: csr_write=1, csr_addr=1, data as UNPROT with [22:20]=sector, one cycle; poll counter cleared -> E_RD.
REQ-022 E_RD: csr_read=1, csr_addr=0, one cycle, poll counter +1 -> E_CHK.
REQ-023 E_CHK: readdata[1:0]!=00 -> E_RD; ==00 and readdata[4]=1 -> WR; ==00 and readdata[4]=0 -> ERR_PROT, err_code=10.
REQ-024 E_CHK: poll counter reaching POLL_LIMIT with busy bits still nonzero -> ERR_PROT, err_code=11; busy/idle decision takes priority only when counter < POLL_LIMIT.
REQ-025 WR: write_go=1; counter increments each cycle; write_done=1 -> PROT (write_go low next cycle); counter=POLL_LIMIT first -> ERR_PROT, err_code=11; write_done on same cycle as limit counts as success.
REQ-026 PROT: csr_write=1, csr_addr=1, csr_writedata=CTRL_IDLE, one cycle -> DONE.
REQ-027 DONE: done=1 one cycle, busy=0 -> IDLE.
REQ-028 ERR_PROT: csr_write of CTRL_IDLE one cycle, err=1 -> IDLE.
REQ-029 csr_read and csr_write never high together; csr_writedata=CTRL_IDLE whenever csr_write=0.
REQ-030 busy=1 in every state except IDLE and DONE.
REQ-031 write_done outside WR ignored.
REQ-032 Poll counter 24 bits, saturating, never wraps.

Reset
REQ-033 rst=1 at any clock edge: state IDLE, csr_read/csr_write/write_go/busy/done/err=0, err_code=00, csr_addr=0, csr_writedata=CTRL_IDLE, counter=0, latched sector=0.
REQ-034 rst mid-operation abandons sequence without issuing the PROT write; rst overrides start on the same edge.

Verification
REQ-035 start, sector=1; status 01 x3 then 0x10 -> writes 32'hFF7F_FFFF, 32'hFF1F_FFFF; 4 reads; write_go until write_done; write 32'hFFFF_FFFF; done pulse, err=0.
REQ-036 start, sector=6 -> no CSR activity, err=1, err_code=01, busy=0.
REQ-037 Status returns 0x00 after erase (success bit clear) -> ERR_PROT write 32'hFFFF_FFFF, err_code=10, write_go never asserted.
REQ-038 POLL_LIMIT=4, status stuck 01 -> exactly 4 reads, err_code=11, protect write issued; repeat with write_done never asserted -> err_code=11 after 4 WR cycles.
REQ-039 rst asserted during WR -> next cycle all outputs at reset values, no protect write; subsequent start sector=5 completes with unprotect word 32'hF7FF_FFFF.
REQ-040 start pulsed during E_RD/WR -> ignored, sequence and latched sector unchanged.
